// File: rtl/up_dn_cmd_ctrl_pkg.sv
// Shared constants and types for the up/down counter command stage.
// The optional auto-repeat feature is enabled with the AUTO_REPEAT_EN macro.
package up_dn_pkg;

    localparam int WIDTH = 5;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_LOAD,
        CMD_DOWN,
        CMD_UP
    } cmd_t;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD,
        RPT_REPEAT
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/up_dn_cmd_ctrl_btn_debounce.sv
// One pushbutton: 2-flop synchroniser, debounce counter and registered rising-edge pulse.
// Level changes are accepted only after DB_CYCLES consecutive synchronised cycles at the new value.
module btn_debounce
    import up_dn_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        cnt_d    = '0;
        // Any cycle where the synced input agrees with the stable level restarts the count.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                rise_d   = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;

endmodule

// File: rtl/up_dn_cmd_ctrl.sv
// Command stage for the 5-bit up/down counter: debounced buttons -> exclusive Load/Down/Up pulses.
// Define AUTO_REPEAT_EN to add hold-to-repeat on Up/Down.
module up_dn_cmd_ctrl
    import up_dn_pkg::*;
#(
    parameter int WIDTH       = up_dn_pkg::WIDTH,
    parameter int DB_CYCLES   = 16,
    parameter int HOLD_CYCLES = 64,
    parameter int RPT_CYCLES  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN_UP,
    input  logic             BTN_DN,
    input  logic             BTN_LD,
    input  logic [WIDTH-1:0] SW,
    input  logic             High,
    input  logic             Low,
    output logic [WIDTH-1:0] IN,
    output logic             Load,
    output logic             Up,
    output logic             Down,
    output logic             Err
);

    if (DB_CYCLES < 2 || HOLD_CYCLES < 1 || RPT_CYCLES < 1) begin : g_bad_params
        $error("up_dn_cmd_ctrl: DB_CYCLES must be >= 2, HOLD/RPT_CYCLES >= 1");
    end

    logic             up_level, up_rise;
    logic             dn_level, dn_rise;
    logic             ld_level, ld_rise;
    logic [WIDTH-1:0] sw_meta_q, sw_meta_d;
    logic [WIDTH-1:0] sw_sync_q, sw_sync_d;
    logic [WIDTH-1:0] in_q, in_d;
    logic             load_q, load_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             err_q, err_d;
    cmd_t             cmd_d;
    logic             unused_levels;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .CLK(CLK), .RST(RST), .raw(BTN_UP), .level(up_level), .rise(up_rise)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .CLK(CLK), .RST(RST), .raw(BTN_DN), .level(dn_level), .rise(dn_rise)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ld (
        .CLK(CLK), .RST(RST), .raw(BTN_LD), .level(ld_level), .rise(ld_rise)
    );

`ifdef AUTO_REPEAT_EN
    localparam int TW = $clog2(max_int(max_int(HOLD_CYCLES, RPT_CYCLES), 2));

    rpt_state_t    rpt_state_q;
    logic [TW-1:0] rpt_timer_q;
    logic          rpt_dir_up_q;
    logic          rec_level, rpt_fire, evt_issued;

    assign rec_level = rpt_dir_up_q ? up_level : dn_level;
    assign rpt_fire  = rec_level &&
                       ((rpt_state_q == RPT_HOLD   && rpt_timer_q == TW'(HOLD_CYCLES - 1)) ||
                        (rpt_state_q == RPT_REPEAT && rpt_timer_q == TW'(RPT_CYCLES - 1)));
    // Only a fresh button event (not a repeat) (re)starts the hold timer.
    assign evt_issued = !ld_rise && (up_rise || dn_rise) &&
                        (cmd_d == CMD_UP || cmd_d == CMD_DOWN);
    assign unused_levels = ld_level;
`else
    assign unused_levels = ^{up_level, dn_level, ld_level};
`endif

    // Fixed priority Load > Down > Up; a losing or limit-blocked event is dropped with Err.
    always_comb begin
        cmd_d = CMD_NONE;
        err_d = 1'b0;
        if (ld_rise) begin
            cmd_d = CMD_LOAD;
            err_d = dn_rise | up_rise;
        end else if (dn_rise) begin
            if (!Low) cmd_d = CMD_DOWN;
            err_d = Low | up_rise;
        end else if (up_rise) begin
            if (!High) cmd_d = CMD_UP;
            err_d = High;
        end
`ifdef AUTO_REPEAT_EN
        else if (rpt_fire) begin
            if (rpt_dir_up_q && !High) cmd_d = CMD_UP;
            else if (!rpt_dir_up_q && !Low) cmd_d = CMD_DOWN;
        end
`endif
    end

    always_comb begin
        sw_meta_d = SW;
        sw_sync_d = sw_meta_q;
        load_d    = (cmd_d == CMD_LOAD);
        down_d    = (cmd_d == CMD_DOWN);
        up_d      = (cmd_d == CMD_UP);
        in_d      = (cmd_d == CMD_LOAD) ? sw_sync_q : in_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            in_q      <= '0;
            load_q    <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            in_q      <= in_d;
            load_q    <= load_d;
            up_q      <= up_d;
            down_q    <= down_d;
            err_q     <= err_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rpt_state_q  <= RPT_IDLE;
            rpt_timer_q  <= '0;
            rpt_dir_up_q <= 1'b0;
        end else if (ld_rise) begin
            rpt_state_q <= RPT_IDLE;
            rpt_timer_q <= '0;
        end else if (evt_issued) begin
            rpt_state_q  <= RPT_HOLD;
            rpt_timer_q  <= '0;
            rpt_dir_up_q <= (cmd_d == CMD_UP);
        end else begin
            case (rpt_state_q)
                RPT_HOLD: begin
                    if (!rec_level) begin
                        rpt_state_q <= RPT_IDLE;
                        rpt_timer_q <= '0;
                    end else if (rpt_timer_q == TW'(HOLD_CYCLES - 1)) begin
                        rpt_state_q <= RPT_REPEAT;
                        rpt_timer_q <= '0;
                    end else begin
                        rpt_timer_q <= rpt_timer_q + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (!rec_level) begin
                        rpt_state_q <= RPT_IDLE;
                        rpt_timer_q <= '0;
                    end else if (rpt_timer_q == TW'(RPT_CYCLES - 1)) begin
                        rpt_timer_q <= '0;
                    end else begin
                        rpt_timer_q <= rpt_timer_q + 1'b1;
                    end
                end
                default: begin
                    rpt_state_q <= RPT_IDLE;
                    rpt_timer_q <= '0;
                end
            endcase
        end
    end
`endif

    assign IN   = in_q;
    assign Load = load_q;
    assign Up   = up_q;
    assign Down = down_q;
    assign Err  = err_q;

endmodule

// File: tb/tb_up_dn_cmd_ctrl.sv
// Directed bench for up_dn_cmd_ctrl with DB_CYCLES=4, HOLD_CYCLES=8, RPT_CYCLES=4.
// Expected values follow the AUTO_REPEAT_EN setting used for the build.
module tb_up_dn_cmd_ctrl;
    import up_dn_pkg::*;

    localparam int W    = 5;
    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int RPT  = 4;
    localparam int WIN  = 28;
`ifdef AUTO_REPEAT_EN
    localparam int V0_UP = 4;
`else
    localparam int V0_UP = 1;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         BTN_UP, BTN_DN, BTN_LD;
    logic [W-1:0] SW;
    logic         High, Low;
    logic [W-1:0] IN;
    logic         Load, Up, Down, Err;

    int n_checks = 0;
    int n_fail   = 0;

    up_dn_cmd_ctrl #(
        .WIDTH(W), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)
    ) dut (
        .CLK(CLK), .RST(RST), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_LD(BTN_LD),
        .SW(SW), .High(High), .Low(Low), .IN(IN),
        .Load(Load), .Up(Up), .Down(Down), .Err(Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit up, dn, ld;
        int sw;
        bit hi, lo;
        int hold;
        int e_ld, e_up, e_dn, e_err, e_edge, e_in;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(bit up, bit dn, bit ld, int sw, bit hi, bit lo, int hold,
                                int e_ld, int e_up, int e_dn, int e_err, int e_edge, int e_in);
        vec_t v;
        v.up = up; v.dn = dn; v.ld = ld; v.sw = sw; v.hi = hi; v.lo = lo; v.hold = hold;
        v.e_ld = e_ld; v.e_up = e_up; v.e_dn = e_dn; v.e_err = e_err;
        v.e_edge = e_edge; v.e_in = e_in;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        @(negedge CLK);
        BTN_UP = 0; BTN_DN = 0; BTN_LD = 0; High = 0; Low = 0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, " Load"}, int'(Load), 0);
        check({name, " Up"},   int'(Up),   0);
        check({name, " Down"}, int'(Down), 0);
        check({name, " Err"},  int'(Err),  0);
        check({name, " IN"},   int'(IN),   0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n_ld = 0, n_up = 0, n_dn = 0, n_err = 0, first = 0, excl = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge CLK);
        BTN_UP = v.up; BTN_DN = v.dn; BTN_LD = v.ld;
        SW = W'(v.sw); High = v.hi; Low = v.lo;
        for (int e = 1; e <= WIN; e++) begin
            @(posedge CLK);
            #1;
            if (Load) n_ld++;
            if (Up)   n_up++;
            if (Down) n_dn++;
            if (Err)  n_err++;
            if ((Load || Up || Down || Err) && first == 0) first = e;
            if (int'(Load) + int'(Up) + int'(Down) > 1) excl++;
            if (e == v.hold) begin
                @(negedge CLK);
                BTN_UP = 0; BTN_DN = 0; BTN_LD = 0;
            end
        end
        check({tag, " load_pulses"}, n_ld, v.e_ld);
        check({tag, " up_pulses"},   n_up, v.e_up);
        check({tag, " down_pulses"}, n_dn, v.e_dn);
        check({tag, " err_pulses"},  n_err, v.e_err);
        check({tag, " first_edge"},  first, v.e_edge);
        check({tag, " in_value"},    int'(IN), v.e_in);
        check({tag, " exclusive"},   excl, 0);
        idle(12);
    endtask

    // btn: 0=up, 1=down. Reset is pulled while the button is held, then released with it still held.
    task automatic reset_during_press(input string name, input int btn, input int after_edges);
        int n_cmd = 0, n_other = 0, first = 0;
        @(negedge CLK);
        if (btn == 0) BTN_UP = 1; else BTN_DN = 1;
        repeat (after_edges) @(posedge CLK);
        #3;
        RST = 0;
        #1;
        check_outputs_zero({name, " async"});
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge CLK);
            #1;
            if ((btn == 0 && Up) || (btn == 1 && Down)) begin
                n_cmd++;
                if (first == 0) first = e;
            end
            if (Load || Err || (btn == 0 && Down) || (btn == 1 && Up)) n_other++;
            if (e == 6) begin
                @(negedge CLK);
                BTN_UP = 0; BTN_DN = 0;
            end
        end
        check({name, " first_edge"}, first, DB + 3);
        check({name, " pulses"}, n_cmd, 1);
        check({name, " other"}, n_other, 0);
        idle(12);
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic repeat_held_40();
        logic [W-1:0] exp_q[$];
        int n_other = 0;
        exp_q.push_back(W'(7));
        for (int t = 15; t <= 43; t += RPT) exp_q.push_back(W'(t));
        @(negedge CLK);
        BTN_UP = 1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge CLK);
            #1;
            if (Up) begin
                if (exp_q.size() == 0) check("rpt extra_pulse_edge", e, 0);
                else check("rpt pulse_edge", e, int'(exp_q.pop_front()));
            end
            if (Down || Err || Load) n_other++;
            if (e == 40) begin
                @(negedge CLK);
                BTN_UP = 0;
            end
        end
        check("rpt missing_pulses", exp_q.size(), 0);
        check("rpt other", n_other, 0);
        idle(12);
    endtask

    task automatic repeat_blocked_at_high();
        int n_up = 0, n_err = 0;
        @(negedge CLK);
        BTN_UP = 1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge CLK);
            #1;
            if (Up)  n_up++;
            if (Err) n_err++;
            if (e == 7) High = 1;
            if (e == 30) begin
                @(negedge CLK);
                BTN_UP = 0;
            end
        end
        check("rpt_high up_pulses", n_up, 1);
        check("rpt_high err_pulses", n_err, 0);
        idle(12);
    endtask
`endif

    initial begin
        //           up dn ld sw  hi lo hold | ld up    dn err edge in
        vecs[0]  = mk(1, 0, 0, 0,  0, 0, 20,   0, V0_UP, 0, 0,  7,   0);
        vecs[1]  = mk(0, 1, 0, 0,  0, 0, 3,    0, 0,     0, 0,  0,   0);
        vecs[2]  = mk(0, 1, 0, 0,  0, 0, 6,    0, 0,     1, 0,  7,   0);
        vecs[3]  = mk(1, 0, 1, 19, 0, 0, 6,    1, 0,     0, 1,  7,   19);
        vecs[4]  = mk(0, 1, 0, 19, 0, 1, 6,    0, 0,     0, 1,  7,   19);
        vecs[5]  = mk(1, 0, 0, 19, 1, 0, 6,    0, 0,     0, 1,  7,   19);
        vecs[6]  = mk(1, 0, 0, 3,  0, 1, 6,    0, 1,     0, 0,  7,   19);
        vecs[7]  = mk(1, 1, 1, 7,  0, 0, 6,    1, 0,     0, 1,  7,   7);
        vecs[8]  = mk(1, 1, 0, 7,  0, 0, 6,    0, 0,     1, 1,  7,   7);
        vecs[9]  = mk(1, 1, 0, 7,  0, 1, 6,    0, 0,     0, 1,  7,   7);
        vecs[10] = mk(0, 0, 1, 31, 1, 1, 6,    1, 0,     0, 0,  7,   31);
        vecs[11] = mk(0, 1, 0, 31, 0, 0, 4,    0, 0,     1, 0,  7,   31);

        RST = 0;
        BTN_UP = 0; BTN_DN = 0; BTN_LD = 0; SW = '0; High = 0; Low = 0;
        repeat (3) @(posedge CLK);
        #1;
        check_outputs_zero("reset");
        @(negedge CLK);
        RST = 1;
        idle(4);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        reset_during_press("rst_debounce", 1, 4);
`ifdef AUTO_REPEAT_EN
        repeat_held_40();
        repeat_blocked_at_high();
`endif
        reset_during_press("rst_repeat", 0, 21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
